led_bank: RTL

Parametrised LED bank driver for the Kéfir I board family.
- Drives N active-high LED outputs in one of four runtime-selectable modes: all on, all off, blink, chase.
- Applies an optional global PWM brightness.
- Sits directly between board-level control logic and the LED pins, replacing hard-wired constant LED assignments.

---
 rtl/led_bank.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/led_bank.sv
// rtl/led_bank.sv - LED bank driver: all-on, all-off, blink and chase patterns with optional PWM dimming
// Optional feature macro: LED_BANK_PWM_EN (global PWM brightness gating via bright)
module led_bank #(
  parameter int N    = 4,
  parameter int DIV  = 12000,
  parameter int STEP = 250
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   mode,
  input  logic [7:0]   bright,
  output logic [N-1:0] leds
);

  // Counter widths: $clog2 of the range, never narrower than one bit
  localparam int PW = (DIV  > 1) ? $clog2(DIV)  : 1;
  localparam int SW = (STEP > 1) ? $clog2(STEP) : 1;
  localparam int QW = (N    > 1) ? $clog2(N)    : 1;

  localparam logic [PW-1:0] PCNT_MAX = PW'(DIV - 1);
  localparam logic [SW-1:0] SCNT_MAX = SW'(STEP - 1);
  localparam logic [QW-1:0] POS_MAX  = QW'(N - 1);

  localparam logic [1:0] MODE_ON    = 2'd0;
  localparam logic [1:0] MODE_OFF   = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_CHASE = 2'd3;

  logic [PW-1:0] pcnt;
  logic [PW-1:0] pcnt_nxt;
  logic [SW-1:0] scnt;
  logic [SW-1:0] scnt_nxt;
  logic [QW-1:0] pos;
  logic [QW-1:0] pos_nxt;
  logic          phase;
  logic          phase_nxt;
  logic [1:0]    mode_q;
  logic          mode_chg;
  logic          tick;
  logic          step;
  logic [N-1:0]  pat;
  logic          pwm_on;

  // Event decode: a mode change overrides any tick/step in the same cycle
  always_comb begin
    mode_chg = (mode != mode_q);
    tick     = (pcnt == PCNT_MAX);
    step     = tick && (scnt == SCNT_MAX);
  end

  // Next values of the prescaler and step counter
  always_comb begin
    pcnt_nxt = pcnt;
    scnt_nxt = scnt;
    if (mode_chg) begin
      pcnt_nxt = '0;
      scnt_nxt = '0;
    end else if (tick) begin
      pcnt_nxt = '0;
      if (scnt == SCNT_MAX) begin
        scnt_nxt = '0;
      end else begin
        scnt_nxt = scnt + SW'(1);
      end
    end else begin
      pcnt_nxt = pcnt + PW'(1);
    end
  end

  // Next animation state; a mode change restarts both animations at their first frame
  always_comb begin
    phase_nxt = phase;
    pos_nxt   = pos;
    if (mode_chg) begin
      phase_nxt = 1'b1;
      pos_nxt   = '0;
    end else if (step) begin
      phase_nxt = ~phase;
      if (pos == POS_MAX) begin
        pos_nxt = '0;
      end else begin
        pos_nxt = pos + QW'(1);
      end
    end
  end

  // Pattern is built from the post-edge animation state so leds shows a new frame
  // on the same edge that the step or mode change takes effect
  always_comb begin
    pat = '0;
    case (mode)
      MODE_ON:    pat = '1;
      MODE_OFF:   pat = '0;
      MODE_BLINK: pat = {N{phase_nxt}};
      MODE_CHASE: pat = N'(1) << pos_nxt;
      default:    pat = '0;
    endcase
  end

  // Timebase and animation state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt   <= '0;
      scnt   <= '0;
      pos    <= '0;
      phase  <= 1'b1;
      mode_q <= MODE_ON;
    end else begin
      pcnt   <= pcnt_nxt;
      scnt   <= scnt_nxt;
      pos    <= pos_nxt;
      phase  <= phase_nxt;
      mode_q <= mode;
    end
  end

`ifdef LED_BANK_PWM_EN
  logic [7:0] wcnt;

  // Free-running PWM counter; deliberately not cleared on mode change
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt <= 8'd0;
    end else begin
      wcnt <= wcnt + 8'd1;
    end
  end

  // Full scale is forced on so 255 means steady light rather than 255/256 duty
  always_comb begin
    pwm_on = (bright == 8'hFF) | (wcnt < bright);
  end
`else
  logic unused_bright;

  // Brightness control compiled out: outputs follow the pattern directly
  always_comb begin
    pwm_on        = 1'b1;
    unused_bright = ^bright;
  end
`endif

  // Registered LED drive, gated by the PWM enable
  always_ff @(posedge clk) begin
    if (rst) begin
      leds <= '0;
    end else begin
      leds <= pat & {N{pwm_on}};
    end
  end

endmodule
